// File: rtl/vga_scan_palette.sv
// VGA scan generator with a 256x24 writable palette. The colour index returned for
// addr_x/addr_y comes out as registered RGB two clocks later, with sync and blank aligned to it.
module vga_scan_palette #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int MOVE_DIV = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic [9:0]  addr_x,
  output logic [9:0]  addr_y,
  input  logic [7:0]  pixel_index,
  input  logic        pal_we,
  input  logic [7:0]  pal_waddr,
  input  logic [23:0] pal_wdata,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        frame_tick,
  output logic [13:0] move_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0]  V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0]  HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [13:0] MOVE_LAST = 14'(MOVE_DIV - 1);

  logic [9:0]  h_count;
  logic [9:0]  v_count;
  logic [9:0]  h_next;
  logic [9:0]  v_next;
  logic        started;
  logic        active_raw;
  logic        hs_raw;
  logic        vs_raw;
  logic [7:0]  index_q;
  logic        active_q;
  logic        hs_q;
  logic        vs_q;
  logic [23:0] rgb;
  logic [23:0] palette [0:255];

  assign addr_x = h_count;
  assign addr_y = v_count;
  assign {r, g, b} = rgb;

  // The first edge after reset only marks the scan as started, so (0,0) gets a full pixel slot.
  always_comb begin
    h_next = h_count;
    v_next = v_count;
    if (started) begin
      if (h_count == H_LAST) begin
        h_next = '0;
        v_next = (v_count == V_LAST) ? '0 : v_count + 10'd1;
      end else begin
        h_next = h_count + 10'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      started    <= 1'b0;
      h_count    <= '0;
      v_count    <= '0;
      frame_tick <= 1'b0;
      move_count <= '0;
    end else begin
      started    <= 1'b1;
      h_count    <= h_next;
      v_count    <= v_next;
      frame_tick <= (h_next == '0) && (v_next == '0);
      // Update together with the tick so the value holds for every pixel of the new frame.
      if ((h_next == '0) && (v_next == '0))
        move_count <= (move_count == MOVE_LAST) ? '0 : move_count + 14'd1;
    end
  end

  assign active_raw = started && (h_count < H_VIS) && (v_count < V_VIS);
  assign hs_raw     = started && (h_count >= HS_START) && (h_count < HS_END);
  assign vs_raw     = started && (v_count >= VS_START) && (v_count < VS_END);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      index_q  <= '0;
      active_q <= 1'b0;
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
    end else begin
      index_q  <= pixel_index;
      active_q <= active_raw;
      hs_q     <= hs_raw;
      vs_q     <= vs_raw;
    end
  end

  // Palette contents survive reset; a same-cycle write and read returns the old entry.
  always_ff @(posedge clock) begin
    if (pal_we)
      palette[pal_waddr] <= pal_wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rgb     <= '0;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      blank_n <= 1'b0;
    end else begin
      rgb     <= active_q ? palette[index_q] : 24'd0;
      hsync   <= ~hs_q;
      vsync   <= ~vs_q;
      blank_n <= active_q;
    end
  end

endmodule
